// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller.
//   - Register byte offsets inside the register window.
//   - CLAIM_VALID_BIT: bit of the CLAIM read value that flags a valid id.
//   - lowest_set(): index of the lowest set bit of a 32-bit vector.
//     Returns 0 for an all-zero vector, so callers must qualify it.
package irq_ctrl_pkg;

    localparam logic [7:0] REG_ENABLE  = 8'h00;
    localparam logic [7:0] REG_TYPE    = 8'h04;
    localparam logic [7:0] REG_PENDING = 8'h08;
    localparam logic [7:0] REG_RAW     = 8'h0C;
    localparam logic [7:0] REG_CLAIM   = 8'h10;
    localparam logic [7:0] REG_SWSET   = 8'h14;

    localparam int CLAIM_VALID_BIT = 31;

    // The loop runs from the top bit downward, so the last hit is the lowest.
    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_sync.sv
// Two-flop synchronizer for asynchronous interrupt inputs.
// Ports:
//   clk  - destination clock
//   rst  - synchronous reset, active high
//   d    - asynchronous input vector, W bits
//   q    - synchronized output vector, W bits (2-cycle latency)
module irq_ctrl_sync #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source level / rising-edge detection, enable
// masking, software-settable pending and a claim register, programmed over
// a native valid/ready memory slave port. Drives a registered irq vector.
// Ports:
//   clk_i, rst_i       - clock, synchronous active-high reset
//   irq_i[NSRC-1:0]    - raw interrupt sources
//   mem_valid_i        - access request (held by master until ready)
//   mem_addr_i         - byte address, bits [1:0] ignored
//   mem_wdata_i        - write data
//   mem_wstrb_i        - byte strobes, 0 means read
//   mem_ready_o        - one-cycle acknowledge
//   mem_rdata_o        - read data, valid while mem_ready_o is high
//   irq_o              - registered (pending & enable) vector
//   irq_any_o          - OR of irq_o
// Build option: define IRQ_CTRL_SYNC_EN to pass irq_i through a two-flop
// synchronizer before any other logic (adds 2 cycles to every latency).
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int NSRC   = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NSRC-1:0]   irq_i,
    input  logic              mem_valid_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [31:0]       mem_wdata_i,
    input  logic [3:0]        mem_wstrb_i,
    output logic              mem_ready_o,
    output logic [31:0]       mem_rdata_o,
    output logic [31:0]       irq_o,
    output logic              irq_any_o
);

    localparam logic [31:0] SRC_MASK =
        (NSRC >= 32) ? 32'hFFFF_FFFF : ((32'd1 << NSRC) - 32'd1);

    logic [NSRC-1:0] irq_src;

`ifdef IRQ_CTRL_SYNC_EN
    irq_ctrl_sync #(.W(NSRC)) u_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (irq_i),
        .q   (irq_src)
    );
`else
    assign irq_src = irq_i;
`endif

    logic [31:0] irq_w;
    assign irq_w = 32'(irq_src);

    logic [31:0] enable_q, type_q, pend_q, raw_q;
    logic [31:0] enable_nxt, type_nxt, pend_nxt;
    logic [31:0] sw_set, w1c, claim_clr, edge_set, rdata_nxt;
    logic [31:0] pend_vis, claim_vec, byte_mask;
    logic [ADDR_W-1:0] word;
    logic [4:0] claim_id;
    logic take, is_wr, is_rd, claim_any;

    // A request is only sampled outside the ready cycle, so each access is
    // accepted exactly once even though the master still holds valid.
    assign take  = mem_valid_i & ~mem_ready_o;
    assign is_wr = take & (|mem_wstrb_i);
    assign is_rd = take & ~(|mem_wstrb_i);
    assign word  = mem_addr_i & ~ADDR_W'(3);

    assign byte_mask = {{8{mem_wstrb_i[3]}}, {8{mem_wstrb_i[2]}},
                        {8{mem_wstrb_i[1]}}, {8{mem_wstrb_i[0]}}};

    assign pend_vis  = (type_q & pend_q) | (~type_q & irq_w & SRC_MASK);
    assign claim_vec = pend_vis & enable_q;
    assign claim_any = |claim_vec;
    assign claim_id  = lowest_set(claim_vec);
    assign edge_set  = irq_w & ~raw_q & type_q;

    always_comb begin
        enable_nxt = enable_q;
        type_nxt   = type_q;
        sw_set     = '0;
        w1c        = '0;
        claim_clr  = '0;
        rdata_nxt  = '0;
        if (is_wr) begin
            case (word)
                ADDR_W'(REG_ENABLE):
                    enable_nxt = ((enable_q & ~byte_mask) | (mem_wdata_i & byte_mask)) & SRC_MASK;
                ADDR_W'(REG_TYPE):
                    type_nxt = ((type_q & ~byte_mask) | (mem_wdata_i & byte_mask)) & SRC_MASK;
                ADDR_W'(REG_PENDING):
                    w1c = mem_wdata_i & byte_mask & type_q;
                ADDR_W'(REG_SWSET):
                    sw_set = mem_wdata_i & byte_mask & type_q;
                default: ;
            endcase
        end
        if (is_rd) begin
            case (word)
                ADDR_W'(REG_ENABLE):  rdata_nxt = enable_q;
                ADDR_W'(REG_TYPE):    rdata_nxt = type_q;
                ADDR_W'(REG_PENDING): rdata_nxt = pend_vis;
                ADDR_W'(REG_RAW):     rdata_nxt = raw_q;
                ADDR_W'(REG_CLAIM): begin
                    if (claim_any) begin
                        rdata_nxt[CLAIM_VALID_BIT] = 1'b1;
                        rdata_nxt[4:0]             = claim_id;
                        // Level sources stay asserted; only latched edges are consumed.
                        claim_clr = type_q & (32'd1 << claim_id);
                    end
                end
                default: ;
            endcase
        end
    end

    // Set terms are OR-ed in after the clears so a coincident event is never lost.
    assign pend_nxt = ((pend_q & ~(w1c | claim_clr | (type_nxt ^ type_q)))
                       | edge_set | sw_set) & SRC_MASK;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            enable_q    <= '0;
            type_q      <= '0;
            pend_q      <= '0;
            raw_q       <= '0;
            mem_ready_o <= 1'b0;
            mem_rdata_o <= '0;
            irq_o       <= '0;
            irq_any_o   <= 1'b0;
        end else begin
            enable_q    <= enable_nxt;
            type_q      <= type_nxt;
            pend_q      <= pend_nxt;
            raw_q       <= irq_w & SRC_MASK;
            mem_ready_o <= take;
            mem_rdata_o <= rdata_nxt;
            irq_o       <= claim_vec;
            irq_any_o   <= claim_any;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// bit-level behavioural model of the register rules.
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] irq;
    logic        valid;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] irq_out;
    logic        irq_any;

    always #5 clk = ~clk;

    irq_ctrl #(.NSRC(32), .ADDR_W(8)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .irq_i       (irq),
        .mem_valid_i (valid),
        .mem_addr_i  (addr),
        .mem_wdata_i (wdata),
        .mem_wstrb_i (wstrb),
        .mem_ready_o (ready),
        .mem_rdata_o (rdata),
        .irq_o       (irq_out),
        .irq_any_o   (irq_any)
    );

`ifdef IRQ_CTRL_SYNC_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 1;
`endif

    int vectors = 0;
    int errors  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_en, m_type, m_pend, m_raw, m_irq, m_rdata, m_s1, m_s2;
    logic        m_any, m_ready, m_rd;

    always @(posedge clk) begin : model
        logic [31:0] in_v, vis, bm, nen, ntype, npend, rv;
        logic        tk, wr, rd, is_edge, s, c;
        logic [7:0]  w;
        int          cid;
        if (rst) begin
            m_en = 0; m_type = 0; m_pend = 0; m_raw = 0; m_irq = 0;
            m_rdata = 0; m_any = 0; m_ready = 0; m_rd = 0; m_s1 = 0; m_s2 = 0;
        end else begin
`ifdef IRQ_CTRL_SYNC_EN
            in_v = m_s2; m_s2 = m_s1; m_s1 = irq;
`else
            in_v = irq;
`endif
            for (int i = 0; i < 32; i++) vis[i] = m_type[i] ? m_pend[i] : in_v[i];
            tk = valid && !m_ready;
            wr = tk && (wstrb != 0);
            rd = tk && (wstrb == 0);
            w  = addr & 8'hFC;
            for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{wstrb[b]}};
            nen = m_en; ntype = m_type; rv = 0; cid = -1;
            if (wr && w == 8'h00) nen   = (m_en & ~bm) | (wdata & bm);
            if (wr && w == 8'h04) ntype = (m_type & ~bm) | (wdata & bm);
            if (rd) begin
                case (w)
                    8'h00: rv = m_en;
                    8'h04: rv = m_type;
                    8'h08: rv = vis;
                    8'h0C: rv = m_raw;
                    8'h10: begin
                        for (int i = 31; i >= 0; i--) if (vis[i] && m_en[i]) cid = i;
                        if (cid >= 0) rv = 32'h8000_0000 + cid;
                    end
                    default: rv = 0;
                endcase
            end
            for (int i = 0; i < 32; i++) begin
                is_edge = m_type[i];
                s = is_edge && ((in_v[i] && !m_raw[i]) ||
                                (wr && w == 8'h14 && wdata[i] && bm[i]));
                c = (is_edge && wr && w == 8'h08 && wdata[i] && bm[i]) ||
                    (is_edge && i == cid) || (ntype[i] != m_type[i]);
                npend[i] = s ? 1'b1 : (c ? 1'b0 : m_pend[i]);
            end
            m_irq   = vis & m_en;
            m_any   = (m_irq != 0);
            m_ready = tk;
            m_rd    = rd;
            m_rdata = rv;
            m_raw   = in_v;
            m_en    = nen;
            m_type  = ntype;
            m_pend  = npend;
        end
    end

    always @(negedge clk) begin
        chk("ready", {31'b0, ready}, {31'b0, m_ready});
        if (m_ready && m_rd) chk("rdata", rdata, m_rdata);
        chk("irq_o", irq_out, m_irq);
        chk("irq_any", {31'b0, irq_any}, {31'b0, m_any});
    end

    // ---------------- stimulus helpers ----------------
    task automatic access(input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] r);
        int n;
        valid = 1'b1; addr = a; wdata = d; wstrb = s; n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ready && n < 10);
        chk("ack", {31'b0, ready}, 32'd1);
        r = rdata;
        valid = 1'b0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        access(a, d, s, r);
    endtask

    task automatic rchk(input string nm, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] r;
        access(a, 32'h0, 4'h0, r);
        chk(nm, r, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic done = 1'b0;
    logic [7:0] addr_tab [8] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h3C, 8'h18};

    initial begin
        int cnt;
        logic prev;
        logic [31:0] r;
        rst = 1'b1; irq = 0; valid = 0; addr = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // reset values
        for (int a = 0; a <= 'h14; a += 4) rchk("reset_reg", 8'(a), 32'h0);
        chk("reset_irq_o", irq_out, 32'h0);

        // level source latency
        wr(8'h00, 32'h20, 4'hF);
        wr(8'h04, 32'h0, 4'hF);
        irq[5] = 1'b1;
        repeat (LAT - 1) @(posedge clk);
        #0 chk("level_early", irq_out, 32'h0);
        @(posedge clk); #1;
        chk("level_rise", irq_out, 32'h20);
        chk("level_any", {31'b0, irq_any}, 32'd1);
        irq[5] = 1'b0;
        repeat (LAT) @(posedge clk);
        #1 chk("level_fall", irq_out, 32'h0);

        // edge + claim
        wr(8'h04, 32'h300, 4'hF);
        wr(8'h00, 32'h300, 4'hF);
        irq[8] = 1'b1; @(posedge clk); #1;
        irq[8] = 1'b0; irq[9] = 1'b1; @(posedge clk); #1;
        irq[9] = 1'b0;
        repeat (LAT + 1) @(posedge clk); #1;
        rchk("edge_pending", 8'h08, 32'h300);
        chk("edge_irq_o", irq_out, 32'h300);
        rchk("claim1", 8'h10, 32'h8000_0008);
        rchk("claim2", 8'h10, 32'h8000_0009);
        rchk("claim3", 8'h10, 32'h0);
        @(posedge clk); #1;
        chk("claim_irq_o", irq_out, 32'h0);

        // W1C colliding with a rising edge
        irq[8] = 1'b1; @(posedge clk); #1;
        irq[8] = 1'b0;
        repeat (LAT + 1) @(posedge clk); #1;
        irq[8] = 1'b1;
        wr(8'h08, 32'h100, 4'hF);
        irq[8] = 1'b0;
        repeat (2) @(posedge clk); #1;
        rchk("collision", 8'h08, 32'h100);

        // SWSET / W1C with byte strobes
        wr(8'h08, 32'h100, 4'hF);
        wr(8'h04, 32'hFFFF_FFFF, 4'hF);
        wr(8'h14, 32'h0000_F000, 4'b0010);
        rchk("swset", 8'h08, 32'h0000_F000);
        wr(8'h08, 32'h0000_3000, 4'hF);
        rchk("w1c", 8'h08, 32'h0000_C000);
        wr(8'h14, 32'h00F0_0000, 4'b0001);
        rchk("swset_strb", 8'h08, 32'h0000_C000);

        // back-to-back with valid held
        valid = 1'b1; addr = 8'h00; wstrb = 0; cnt = 0; prev = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (ready) cnt++;
            if (ready && prev) chk("b2b_no_double", 32'd1, 32'd0);
            prev = ready;
        end
        valid = 1'b0;
        chk("b2b_count", cnt, 32'd4);
        @(posedge clk); #1;

        // unmapped offset
        access(8'h3C, 32'h0, 4'h0, r);
        chk("unmapped_rd", r, 32'h0);
        wr(8'h3C, 32'hFFFF_FFFF, 4'hF);
        rchk("unmapped_wr", 8'h00, 32'h300);

        // reset during an access
        valid = 1'b1; addr = 8'h00; wdata = 32'hFF; wstrb = 4'hF; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_no_ready", {31'b0, ready}, 32'd0);
        valid = 1'b0; rst = 1'b0;
        @(posedge clk); #1;
        rchk("rst_enable", 8'h00, 32'h0);

        // randomized traffic
        fork
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    irq = irq ^ ($urandom & $urandom & $urandom);
                end
            end
            begin
                for (int t = 0; t < 400; t++) begin
                    logic [3:0] s;
                    s = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
                    access(addr_tab[$urandom_range(0, 7)], $urandom, s, r);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
        join
        @(posedge clk); #1;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
